// File: rtl/ahb_burst_addr_gen.sv
// AHB burst address generator: turns one burst request into per-beat HADDR/HTRANS.
// Latency: first address phase one cycle after accept; done pulses one cycle after last beat.
// Backpressure: HREADY=0 freezes the address phase; reqReady is low while a burst runs.
module ahb_burst_addr_gen #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  HCLK,
    input  logic                  HRESET,
    input  logic                  reqValid,
    output logic                  reqReady,
    input  logic [ADDR_WIDTH-1:0] reqAddr,
    input  logic [2:0]            reqBurst,
    input  logic [2:0]            reqSize,
    input  logic                  reqWrite,
    input  logic [4:0]            reqLength,
    input  logic                  HREADY,
    output logic [ADDR_WIDTH-1:0] HADDR,
    output logic [1:0]            HTRANS,
    output logic [2:0]            HBURST,
    output logic [2:0]            HSIZE,
    output logic                  HWRITE,
    output logic                  busy,
    output logic                  done,
    output logic                  reqError
);

    typedef enum logic {ST_IDLE, ST_ACTIVE} state_t;

    // Largest HSIZE the data bus can carry in one beat.
    localparam logic [2:0] MAX_SIZE  = 3'($clog2(DATA_WIDTH / 8));
    localparam logic [1:0] TR_IDLE   = 2'b00;
    localparam logic [1:0] TR_NONSEQ = 2'b10;
    localparam logic [1:0] TR_SEQ    = 2'b11;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [ADDR_WIDTH-1:0] r_haddr;
    logic [1:0]            r_htrans;
    logic [2:0]            r_hburst;
    logic [2:0]            r_hsize;
    logic                  r_hwrite;
    logic                  r_done;
    logic                  r_err;
    logic [4:0]            r_cnt;
    logic [4:0]            r_beats;

    logic [4:0]            w_req_beats;
    logic [ADDR_WIDTH-1:0] w_start_addr;
    logic [ADDR_WIDTH-1:0] w_incr;
    logic [ADDR_WIDTH-1:0] w_wrap_mask;
    logic [ADDR_WIDTH-1:0] w_incr_addr;
    logic [ADDR_WIDTH-1:0] w_next_addr;
    logic                  w_accept;
    logic                  w_reject;
    logic                  w_beat;
    logic                  w_last;
    logic                  w_wrap;
    logic                  w_cross;

    assign reqReady = (r_state == ST_IDLE) && !HRESET;
    assign w_accept = reqReady && reqValid && (reqSize <= MAX_SIZE);
    assign w_reject = reqReady && reqValid && (reqSize > MAX_SIZE);
    assign w_beat   = (r_state == ST_ACTIVE) && HREADY;
    assign w_last   = w_beat && (r_cnt == r_beats - 5'd1);

    // Start address is aligned down to the transfer size.
    assign w_start_addr = reqAddr & ~((ADDR_WIDTH'(1) << reqSize) - ADDR_WIDTH'(1));

    // Next-address arithmetic; wrap bursts keep the upper bits above the wrap boundary.
    assign w_incr      = ADDR_WIDTH'(1) << r_hsize;
    assign w_wrap_mask = (ADDR_WIDTH'(r_beats) << r_hsize) - ADDR_WIDTH'(1);
    assign w_incr_addr = r_haddr + w_incr;
    assign w_wrap      = (r_hburst[0] == 1'b0) && (r_hburst != 3'b000);
    assign w_next_addr = w_wrap ? ((r_haddr & ~w_wrap_mask) | (w_incr_addr & w_wrap_mask))
                                : w_incr_addr;
    // A 1 KB crossing on an incrementing burst must restart as NONSEQ.
    assign w_cross     = !w_wrap && (w_next_addr[ADDR_WIDTH-1:10] != r_haddr[ADDR_WIDTH-1:10]);

    // Beat count of the incoming request; INCR length is clamped to 1..16.
    always_comb begin
        w_req_beats = 5'd1;
        case (reqBurst)
            3'b000:         w_req_beats = 5'd1;
            3'b001: begin
                if (reqLength == 5'd0)       w_req_beats = 5'd1;
                else if (reqLength > 5'd16)  w_req_beats = 5'd16;
                else                         w_req_beats = reqLength;
            end
            3'b010, 3'b011: w_req_beats = 5'd4;
            3'b100, 3'b101: w_req_beats = 5'd8;
            default:        w_req_beats = 5'd16;
        endcase
    end

    // State register.
    always_ff @(posedge HCLK) begin
        if (HRESET) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    // Next state: enter ACTIVE on accept, leave after the last beat is taken.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:   if (w_accept) w_state_nxt = ST_ACTIVE;
            ST_ACTIVE: if (w_last)   w_state_nxt = ST_IDLE;
            default:   w_state_nxt = ST_IDLE;
        endcase
    end

    // Address-phase registers, beat counter and status pulses.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            r_haddr  <= '0;
            r_htrans <= TR_IDLE;
            r_hburst <= 3'b000;
            r_hsize  <= 3'b000;
            r_hwrite <= 1'b0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
            r_cnt    <= 5'd0;
            r_beats  <= 5'd1;
        end else begin
            r_done <= w_last;
            r_err  <= w_reject;
            if (w_accept) begin
                r_haddr  <= w_start_addr;
                r_htrans <= TR_NONSEQ;
                r_hburst <= reqBurst;
                r_hsize  <= reqSize;
                r_hwrite <= reqWrite;
                r_cnt    <= 5'd0;
                r_beats  <= w_req_beats;
            end else if (w_beat) begin
                if (w_last) begin
                    r_htrans <= TR_IDLE;
                end else begin
                    r_cnt    <= r_cnt + 5'd1;
                    r_haddr  <= w_next_addr;
                    r_htrans <= w_cross ? TR_NONSEQ : TR_SEQ;
                end
            end
        end
    end

    assign HADDR    = r_haddr;
    assign HTRANS   = r_htrans;
    assign HBURST   = r_hburst;
    assign HSIZE    = r_hsize;
    assign HWRITE   = r_hwrite;
    assign busy     = (r_state == ST_ACTIVE);
    assign done     = r_done;
    assign reqError = r_err;

endmodule

// File: tb/tb_ahb_burst_addr_gen.sv
// Bench for ahb_burst_addr_gen: directed bursts checked against a per-beat address model.
// Latency: expected beats are queued after the accepting edge and compared every cycle.
// Backpressure: HREADY stalls are driven per test; held outputs are compared while stalled.
module tb_ahb_burst_addr_gen;

    logic        HCLK = 1'b0;
    logic        HRESET;
    logic        reqValid;
    logic        reqReady;
    logic [31:0] reqAddr;
    logic [2:0]  reqBurst;
    logic [2:0]  reqSize;
    logic        reqWrite;
    logic [4:0]  reqLength;
    logic        HREADY;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic [2:0]  HBURST;
    logic [2:0]  HSIZE;
    logic        HWRITE;
    logic        busy;
    logic        done;
    logic        reqError;

    ahb_burst_addr_gen #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .HCLK(HCLK), .HRESET(HRESET), .reqValid(reqValid), .reqReady(reqReady),
        .reqAddr(reqAddr), .reqBurst(reqBurst), .reqSize(reqSize), .reqWrite(reqWrite),
        .reqLength(reqLength), .HREADY(HREADY), .HADDR(HADDR), .HTRANS(HTRANS),
        .HBURST(HBURST), .HSIZE(HSIZE), .HWRITE(HWRITE), .busy(busy), .done(done),
        .reqError(reqError)
    );

    always #5 HCLK = ~HCLK;

    int total = 0;
    int bad   = 0;

    logic [31:0] exp_addr[$];
    logic [1:0]  exp_trans[$];
    logic [2:0]  exp_burst;
    logic [2:0]  exp_size;
    logic        exp_write;
    logic        done_due = 1'b0;
    logic        err_due  = 1'b0;
    logic        chk_en   = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: list every beat's address and transfer type from burst rules.
    task automatic model_burst(input logic [31:0] addr, input logic [2:0] burst,
                               input logic [2:0] size, input logic [4:0] len);
        int          n;
        logic [31:0] inc, start, bnd, base, a, prev;
        logic        wrap;
        case (burst)
            3'd0:       n = 1;
            3'd1:       n = (len == 0) ? 1 : ((len > 16) ? 16 : int'(len));
            3'd2, 3'd3: n = 4;
            3'd4, 3'd5: n = 8;
            default:    n = 16;
        endcase
        wrap  = (burst == 3'd2) || (burst == 3'd4) || (burst == 3'd6);
        inc   = 32'd1 << size;
        start = addr - (addr % inc);
        bnd   = inc * n;
        base  = start - (start % bnd);
        prev  = start;
        for (int i = 0; i < n; i++) begin
            if (wrap) a = base + (((start % bnd) + inc * i) % bnd);
            else      a = start + inc * i;
            exp_addr.push_back(a);
            if (i == 0 || (!wrap && (a >> 10) != (prev >> 10))) exp_trans.push_back(2'b10);
            else                                                exp_trans.push_back(2'b11);
            prev = a;
        end
    endtask

    // Per-cycle comparison against the model queue.
    always @(negedge HCLK) begin
        if (chk_en) begin
            check("reqError", reqError, err_due);
            err_due = 1'b0;
            if (exp_addr.size() > 0) begin
                check("HADDR",    HADDR,    exp_addr[0]);
                check("HTRANS",   HTRANS,   exp_trans[0]);
                check("HBURST",   HBURST,   exp_burst);
                check("HSIZE",    HSIZE,    exp_size);
                check("HWRITE",   HWRITE,   exp_write);
                check("busy",     busy,     1'b1);
                check("reqReady", reqReady, 1'b0);
                check("done",     done,     1'b0);
                if (HREADY) begin
                    void'(exp_addr.pop_front());
                    void'(exp_trans.pop_front());
                    if (exp_addr.size() == 0) done_due = 1'b1;
                end
            end else begin
                check("idle_HTRANS", HTRANS,   2'b00);
                check("idle_busy",   busy,     1'b0);
                check("idle_ready",  reqReady, 1'b1);
                check("done",        done,     done_due);
                done_due = 1'b0;
            end
        end
    end

    task automatic start_req(input logic [31:0] addr, input logic [2:0] burst,
                             input logic [2:0] size, input logic wr, input logic [4:0] len);
        reqAddr   = addr;
        reqBurst  = burst;
        reqSize   = size;
        reqWrite  = wr;
        reqLength = len;
        reqValid  = 1'b1;
        @(posedge HCLK);
        #1;
        reqValid = 1'b0;
        if (size <= 3'd2) begin
            exp_burst = burst;
            exp_size  = size;
            exp_write = wr;
            model_burst(addr, burst, size, len);
        end else begin
            err_due = 1'b1;
        end
    endtask

    task automatic run_beats(input int stall_idx, input int stall_n);
        int guard = 0;
        int n_total = exp_addr.size();
        int left = stall_n;
        while (exp_addr.size() > 0 && guard < 200) begin
            if ((n_total - exp_addr.size()) == stall_idx && left > 0) begin
                HREADY = 1'b0;
                left--;
            end else begin
                HREADY = 1'b1;
            end
            @(posedge HCLK);
            #1;
            guard++;
        end
        HREADY = 1'b1;
        check("burst_timeout", exp_addr.size(), 0);
        @(posedge HCLK);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_HTRANS"}, HTRANS, 2'b00);
        check({tag, "_HADDR"},  HADDR,  32'h0);
        check({tag, "_HBURST"}, HBURST, 3'b000);
        check({tag, "_HSIZE"},  HSIZE,  3'b000);
        check({tag, "_HWRITE"}, HWRITE, 1'b0);
        check({tag, "_busy"},   busy,   1'b0);
        check({tag, "_done"},   done,   1'b0);
        check({tag, "_err"},    reqError, 1'b0);
        check({tag, "_ready"},  reqReady, 1'b0);
    endtask

    initial begin
        HRESET = 1'b1; reqValid = 1'b0; reqAddr = '0; reqBurst = '0; reqSize = '0;
        reqWrite = 1'b0; reqLength = '0; HREADY = 1'b1;
        repeat (3) @(posedge HCLK);
        #1;
        check_reset_outputs("rst");
        HRESET = 1'b0;
        chk_en = 1'b1;
        @(posedge HCLK);
        #1;

        // INCR4 word from 0x100.
        start_req(32'h100, 3'b011, 3'd2, 1'b1, 5'd0);
        check("pin_incr4_a3", exp_addr[3], 32'h10C);
        check("pin_incr4_t1", exp_trans[1], 2'b11);
        run_beats(-1, 0);

        // WRAP4 word from 0x38.
        start_req(32'h38, 3'b010, 3'd2, 1'b0, 5'd0);
        check("pin_wrap4_a2", exp_addr[2], 32'h30);
        check("pin_wrap4_a3", exp_addr[3], 32'h34);
        run_beats(-1, 0);

        // WRAP8 byte from 0x07, three stall cycles on the second beat.
        start_req(32'h07, 3'b100, 3'd0, 1'b0, 5'd0);
        check("pin_wrap8_a1", exp_addr[1], 32'h00);
        check("pin_wrap8_a7", exp_addr[7], 32'h06);
        run_beats(1, 3);

        // INCR length 4 across a 1 KB boundary.
        start_req(32'h3F8, 3'b001, 3'd2, 1'b1, 5'd4);
        check("pin_1k_a2", exp_addr[2], 32'h400);
        check("pin_1k_t2", exp_trans[2], 2'b10);
        check("pin_1k_t3", exp_trans[3], 2'b11);
        run_beats(-1, 0);

        // Doubleword on a 32-bit bus is rejected.
        start_req(32'h40, 3'b011, 3'd3, 1'b0, 5'd0);
        @(posedge HCLK);
        #1;

        // INCR length 0 is a single beat.
        start_req(32'h200, 3'b001, 3'd2, 1'b0, 5'd0);
        check("pin_len0_n", exp_addr.size(), 1);
        run_beats(-1, 0);

        // INCR length 20 clamps to 16; unaligned halfword start.
        start_req(32'h1003, 3'b001, 3'd1, 1'b1, 5'd20);
        check("pin_clamp_n", exp_addr.size(), 16);
        check("pin_clamp_a0", exp_addr[0], 32'h1002);
        run_beats(4, 2);

        // WRAP16 halfword, then INCR16 wrapping the top of the address space.
        start_req(32'h0E, 3'b110, 3'd1, 1'b0, 5'd0);
        check("pin_wrap16_a1", exp_addr[1], 32'h10);
        run_beats(-1, 0);
        start_req(32'hFFFF_FFF8, 3'b111, 3'd2, 1'b0, 5'd0);
        check("pin_top_a2", exp_addr[2], 32'h0);
        run_beats(7, 1);

        // Reset during the second beat of INCR8 aborts without done.
        start_req(32'h500, 3'b101, 3'd2, 1'b1, 5'd0);
        HREADY = 1'b1;
        @(posedge HCLK);
        #1;
        chk_en = 1'b0;
        HRESET = 1'b1;
        @(posedge HCLK);
        #1;
        check_reset_outputs("abort");
        @(posedge HCLK);
        #1;
        check("abort_done2", done, 1'b0);
        exp_addr.delete();
        exp_trans.delete();
        done_due = 1'b0;
        err_due  = 1'b0;
        HRESET   = 1'b0;
        chk_en   = 1'b1;
        @(posedge HCLK);
        #1;
        start_req(32'h44, 3'b000, 3'd2, 1'b1, 5'd0);
        run_beats(-1, 0);
        @(posedge HCLK);
        #1;
        chk_en = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
